controller_fsm: RTL and testbench
=================================

# controller_fsm

Multi-cycle main control unit of the 16-bit processor. Decodes the 4-bit `opcode` and `func_field` of the instruction held in the IR and steps through fetch/decode/execute/memory/writeback states. It drives every datapath select and write-enable: PC, IR, register file, ALU and data memory. It is a Moore machine, and all outputs are a pure function of the current state, plus `opcode`/`func_field` where stated.

## Interface
- Parameters: none.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `opcode` in 4: IR[15:12].
- `func_field` in 4: IR[3:0], the R-type function.
- `PCSrc` out 2: 00 ALU result, 01 ALUOut (branch target), 10 jump target.
- `ALUOp` out 3: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll, 110 srl, 111 slt.
- `sign_extend` out 1: 1 sign-extends the immediate, 0 zero-extends it.
- `ALUSrcA` out 1: 0 PC, 1 register A.
- `ALUSrcB` out 3: 000 register B, 001 constant 2, 010 extended imm, 011 extended imm<<1, others reserved.
- `ReadR1` out 2: 00 IR[11:8], 01 IR[7:4], 10 R0.
- `ReadR2` out 1: 0 IR[7:4], 1 IR[11:8].
- `RegWriteDst` out 1: 0 IR[11:8], 1 IR[7:4].
- `MemToReg` out 1: 0 ALUOut, 1 MDR.
- `PCBEqCond`, `PCBNqCond` out 1 each: conditional PC write on ALU zero / not-zero.
- `PCWrite`, `MemWrite`, `MemRead`, `IRWrite`, `RegWrite` out 1 each: unconditional enables.

## Operation
- Opcode map:
  - 0000 R-type
  - 0001 ADDI (sign-extended)
  - 0010 ANDI (zero-extended)
  - 0011 ORI (zero-extended)
  - 0100 LW
  - 0101 SW
  - 0110 BEQ
  - 0111 BNE
  - 1000 JMP
  - All other opcodes are NOP.
- States, 6-bit register, binary encoding:
  - RESET: all outputs 0.
  - FETCH: IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=001, ALUOp=000, PCSrc=00.
  - DECODE: ALUSrcA=0, ALUSrcB=011, ALUOp=000, sign_extend=1, ReadR1=00, ReadR2=0. Precomputes the branch target into ALUOut.
  - EXEC_R: ALUSrcA=1, ALUSrcB=000, ALUOp=func_field[2:0].
  - EXEC_I: ALUSrcA=1, ALUSrcB=010, ReadR1=01. ALUOp is 000 (ADDI), 010 (ANDI) or 011 (ORI); sign_extend=1 only for ADDI.
  - WB_R: RegWrite=1, RegWriteDst=0, MemToReg=0.
  - WB_I: RegWrite=1, RegWriteDst=0, MemToReg=0.
  - MEM_ADDR: ALUSrcA=1, ReadR1=01, ALUSrcB=010, ALUOp=000, sign_extend=1.
  - MEM_RD: MemRead=1.
  - MEM_WB: RegWrite=1, RegWriteDst=0, MemToReg=1.
  - MEM_WR: MemWrite=1, ReadR2=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=000, ALUOp=001, PCSrc=01. PCBEqCond=1 for BEQ, PCBNqCond=1 for BNE.
  - JUMP: PCWrite=1, PCSrc=10.
- Any output not listed for a state is 0.
- Transitions:
  - RESET→FETCH→DECODE.
  - DECODE → EXEC_R / EXEC_I / MEM_ADDR / BRANCH / JUMP, per opcode.
  - NOP: DECODE→FETCH.
  - EXEC_R→WB_R; EXEC_I→WB_I.
  - MEM_ADDR→MEM_RD (LW) or MEM_WR (SW); MEM_RD→MEM_WB.
  - WB_R, WB_I, MEM_WB, MEM_WR, BRANCH, JUMP → FETCH.
- Datapath PC enable = PCWrite | (PCBEqCond & zero) | (PCBNqCond & ~zero).
- R-type with func_field[3]=1 still executes, using func_field[2:0].
- An unreachable state encoding goes to FETCH on the next edge.

## Timing
- The state register updates on rising `clk`. Outputs are combinational from the state register (plus opcode/func_field in EXEC_R, EXEC_I, MEM_ADDR, BRANCH). Outputs are glitch-tolerant only; datapath samples them on the next edge.
- `rst`=0 at a rising edge puts the machine in RESET, whatever the current state; this includes mid-instruction, and no partial writes complete afterwards. The first edge with `rst`=1 moves it to FETCH.
- Cycles per instruction, counted from FETCH:
  - R-type, I-type, SW: 4
  - LW: 5
  - BEQ/BNE, JMP: 3
  - NOP: 2
- `opcode` is sampled only at the DECODE→next transition and the MEM_ADDR transition. The IR is stable from the edge after FETCH.

## Configuration
- `CTRL_JUMP_EN` defined: opcode 1000 goes DECODE→JUMP, and the JUMP state exists.
- `CTRL_JUMP_EN` undefined: the JUMP state is omitted, opcode 1000 is a NOP (DECODE→FETCH), and PCSrc never equals 10.

## Structure
- Shared package `ctrl_pkg`:
  - state enum
  - opcode localparams
  - ALUOp, ALUSrcB, PCSrc and ReadR1 encodings, shared with the datapath and ALU
- One sub-module is natural: `ctrl_output_decode`, the combinational state→outputs decoder. The next-state logic and state register stay in the top module.

## Test plan
- Reset sequence: `rst`=0 for 1 edge → all outputs 0. Next edge → FETCH with IRWrite=1, PCWrite=1, ALUSrcB=001.
- ORI (opcode 0011) → FETCH, DECODE, EXEC_I (ALUOp=011, sign_extend=0, ALUSrcB=010), WB_I (RegWrite=1); back in FETCH on cycle 5.
- LW (0100) → MEM_ADDR (sign_extend=1), MEM_RD (MemRead=1), MEM_WB (MemToReg=1, RegWrite=1); FETCH after 5 cycles. SW (0101) → MEM_WR (MemWrite=1, ReadR2=1).
- BEQ (0110) → BRANCH with PCBEqCond=1, PCBNqCond=0, PCSrc=01, ALUOp=001. BNE (0111) → PCBNqCond=1 only.
- R-type, func_field=0101 → EXEC_R ALUOp=101. Opcode 1111 → DECODE→FETCH with no write enables.
- `rst`=0 asserted during MEM_RD → RESET next edge, with MemRead, RegWrite and PCWrite all 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller, datapath and ALU.
package ctrl_pkg;

    localparam int unsigned STATE_W  = 6;
    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned FUNC_W   = 4;
    localparam int unsigned ALUOP_W  = 3;
    localparam int unsigned SRCB_W   = 3;
    localparam int unsigned PCSRC_W  = 2;
    localparam int unsigned RR1_W    = 2;

    typedef logic [STATE_W-1:0] state_t;

    // Controller states, binary encoded
    localparam logic [STATE_W-1:0] S_RESET    = 6'd0;
    localparam logic [STATE_W-1:0] S_FETCH    = 6'd1;
    localparam logic [STATE_W-1:0] S_DECODE   = 6'd2;
    localparam logic [STATE_W-1:0] S_EXEC_R   = 6'd3;
    localparam logic [STATE_W-1:0] S_EXEC_I   = 6'd4;
    localparam logic [STATE_W-1:0] S_WB_R     = 6'd5;
    localparam logic [STATE_W-1:0] S_WB_I     = 6'd6;
    localparam logic [STATE_W-1:0] S_MEM_ADDR = 6'd7;
    localparam logic [STATE_W-1:0] S_MEM_RD   = 6'd8;
    localparam logic [STATE_W-1:0] S_MEM_WB   = 6'd9;
    localparam logic [STATE_W-1:0] S_MEM_WR   = 6'd10;
    localparam logic [STATE_W-1:0] S_BRANCH   = 6'd11;
    localparam logic [STATE_W-1:0] S_JUMP     = 6'd12;

    // Opcodes (IR[15:12])
    localparam logic [OPCODE_W-1:0] OP_RTYPE = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_LW    = 4'b0100;
    localparam logic [OPCODE_W-1:0] OP_SW    = 4'b0101;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 4'b0110;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 4'b0111;
    localparam logic [OPCODE_W-1:0] OP_JMP   = 4'b1000;

    // ALU operations
    localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALUOP_W-1:0] ALU_XOR = 3'b100;
    localparam logic [ALUOP_W-1:0] ALU_SLL = 3'b101;
    localparam logic [ALUOP_W-1:0] ALU_SRL = 3'b110;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 3'b111;

    // ALU B operand select
    localparam logic [SRCB_W-1:0] SRCB_REG    = 3'b000;
    localparam logic [SRCB_W-1:0] SRCB_TWO    = 3'b001;
    localparam logic [SRCB_W-1:0] SRCB_IMM    = 3'b010;
    localparam logic [SRCB_W-1:0] SRCB_IMM_SH = 3'b011;

    // PC source select
    localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'b10;

    // Register file read port 1 select
    localparam logic [RR1_W-1:0] RR1_IR_11_8 = 2'b00;
    localparam logic [RR1_W-1:0] RR1_IR_7_4  = 2'b01;
    localparam logic [RR1_W-1:0] RR1_R0      = 2'b10;

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational state -> datapath control decoder (Moore outputs).
// CTRL_JUMP_EN: when defined, the JUMP state drives PCWrite with the jump target.
module ctrl_output_decode
    import ctrl_pkg::*;
(
    input  logic [STATE_W-1:0]  state,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [ALUOP_W-1:0]  func_op,
    output logic [PCSRC_W-1:0]  PCSrc,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                sign_extend,
    output logic                ALUSrcA,
    output logic [SRCB_W-1:0]   ALUSrcB,
    output logic [RR1_W-1:0]    ReadR1,
    output logic                ReadR2,
    output logic                RegWriteDst,
    output logic                MemToReg,
    output logic                PCBEqCond,
    output logic                PCBNqCond,
    output logic                PCWrite,
    output logic                MemWrite,
    output logic                MemRead,
    output logic                IRWrite,
    output logic                RegWrite
);

    // Every output defaults to 0; each state raises only what it needs
    always_comb begin
        PCSrc       = PCSRC_ALU;
        ALUOp       = ALU_ADD;
        sign_extend = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ReadR1      = RR1_IR_11_8;
        ReadR2      = 1'b0;
        RegWriteDst = 1'b0;
        MemToReg    = 1'b0;
        PCBEqCond   = 1'b0;
        PCBNqCond   = 1'b0;
        PCWrite     = 1'b0;
        MemWrite    = 1'b0;
        MemRead     = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;

        case (state)
            S_FETCH: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = SRCB_TWO;
            end
            S_DECODE: begin
                // Branch target PC + (imm<<1) lands in ALUOut
                ALUSrcB     = SRCB_IMM_SH;
                sign_extend = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = func_op;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ReadR1  = RR1_IR_7_4;
                case (opcode)
                    OP_ADDI: begin
                        ALUOp       = ALU_ADD;
                        sign_extend = 1'b1;
                    end
                    OP_ANDI: ALUOp = ALU_AND;
                    OP_ORI:  ALUOp = ALU_OR;
                    default: ALUOp = ALU_ADD;
                endcase
            end
            S_WB_R, S_WB_I: begin
                RegWrite = 1'b1;
            end
            S_MEM_ADDR: begin
                ALUSrcA     = 1'b1;
                ReadR1      = RR1_IR_7_4;
                ALUSrcB     = SRCB_IMM;
                sign_extend = 1'b1;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                ReadR2   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA   = 1'b1;
                ALUOp     = ALU_SUB;
                PCSrc     = PCSRC_ALUOUT;
                PCBEqCond = (opcode == OP_BEQ);
                PCBNqCond = (opcode == OP_BNE);
            end
`ifdef CTRL_JUMP_EN
            S_JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = PCSRC_JUMP;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/controller_fsm.sv
// Multi-cycle main control unit: state register and next-state logic.
// CTRL_JUMP_EN: when defined, opcode 1000 executes as JMP; otherwise it is a NOP.
module controller_fsm
    import ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNC_W-1:0]   func_field,
    output logic [PCSRC_W-1:0]  PCSrc,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                sign_extend,
    output logic                ALUSrcA,
    output logic [SRCB_W-1:0]   ALUSrcB,
    output logic [RR1_W-1:0]    ReadR1,
    output logic                ReadR2,
    output logic                RegWriteDst,
    output logic                MemToReg,
    output logic                PCBEqCond,
    output logic                PCBNqCond,
    output logic                PCWrite,
    output logic                MemWrite,
    output logic                MemRead,
    output logic                IRWrite,
    output logic                RegWrite
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;

    // func_field[3] carries no meaning: R-type always executes func_field[2:0]
    logic w_unused_func;
    assign w_unused_func = func_field[3];

    // State register, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; unreachable encodings recover through FETCH
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_RESET:  w_next_state = S_FETCH;
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:                w_next_state = S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI: w_next_state = S_EXEC_I;
                    OP_LW, OP_SW:            w_next_state = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:          w_next_state = S_BRANCH;
`ifdef CTRL_JUMP_EN
                    OP_JMP:                  w_next_state = S_JUMP;
`endif
                    default:                 w_next_state = S_FETCH;
                endcase
            end
            S_EXEC_R: w_next_state = S_WB_R;
            S_EXEC_I: w_next_state = S_WB_I;
            S_MEM_ADDR: begin
                case (opcode)
                    OP_LW:   w_next_state = S_MEM_RD;
                    OP_SW:   w_next_state = S_MEM_WR;
                    default: w_next_state = S_FETCH;
                endcase
            end
            S_MEM_RD: w_next_state = S_MEM_WB;
            default:  w_next_state = S_FETCH;
        endcase
    end

    // State -> control outputs
    ctrl_output_decode u_output_decode (
        .state       (r_state),
        .opcode      (opcode),
        .func_op     (func_field[2:0]),
        .PCSrc       (PCSrc),
        .ALUOp       (ALUOp),
        .sign_extend (sign_extend),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ReadR1      (ReadR1),
        .ReadR2      (ReadR2),
        .RegWriteDst (RegWriteDst),
        .MemToReg    (MemToReg),
        .PCBEqCond   (PCBEqCond),
        .PCBNqCond   (PCBNqCond),
        .PCWrite     (PCWrite),
        .MemWrite    (MemWrite),
        .MemRead     (MemRead),
        .IRWrite     (IRWrite),
        .RegWrite    (RegWrite)
    );

endmodule

// File: tb/tb_controller_fsm.sv
// Directed bench for controller_fsm: walks each instruction class state by state.
module tb_controller_fsm;

    logic       clk;
    logic       rst;
    logic [3:0] opcode;
    logic [3:0] func_field;
    logic [1:0] PCSrc;
    logic [2:0] ALUOp;
    logic       sign_extend;
    logic       ALUSrcA;
    logic [2:0] ALUSrcB;
    logic [1:0] ReadR1;
    logic       ReadR2;
    logic       RegWriteDst;
    logic       MemToReg;
    logic       PCBEqCond;
    logic       PCBNqCond;
    logic       PCWrite;
    logic       MemWrite;
    logic       MemRead;
    logic       IRWrite;
    logic       RegWrite;

    int n_checks;
    int n_fails;

    controller_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .func_field  (func_field),
        .PCSrc       (PCSrc),
        .ALUOp       (ALUOp),
        .sign_extend (sign_extend),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ReadR1      (ReadR1),
        .ReadR2      (ReadR2),
        .RegWriteDst (RegWriteDst),
        .MemToReg    (MemToReg),
        .PCBEqCond   (PCBEqCond),
        .PCBNqCond   (PCBNqCond),
        .PCWrite     (PCWrite),
        .MemWrite    (MemWrite),
        .MemRead     (MemRead),
        .IRWrite     (IRWrite),
        .RegWrite    (RegWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack a full control word: pcsrc,aluop,se,srca,srcb,rr1,rr2,rwd,m2r,beq,bnq,pcw,mw,mr,irw,rw
    function automatic logic [31:0] pk(
        input logic [1:0] pcsrc, input logic [2:0] aluop, input logic se,
        input logic srca, input logic [2:0] srcb, input logic [1:0] rr1,
        input logic rr2, input logic rwd, input logic m2r, input logic beq,
        input logic bnq, input logic pcw, input logic mw, input logic mr,
        input logic irw, input logic rw);
        pk = 32'({pcsrc, aluop, se, srca, srcb, rr1, rr2, rwd, m2r,
                  beq, bnq, pcw, mw, mr, irw, rw});
    endfunction

    function automatic logic [31:0] observed();
        observed = pk(PCSrc, ALUOp, sign_extend, ALUSrcA, ALUSrcB, ReadR1, ReadR2,
                      RegWriteDst, MemToReg, PCBEqCond, PCBNqCond, PCWrite,
                      MemWrite, MemRead, IRWrite, RegWrite);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one active edge and settle on the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hand-computed control words
    logic [31:0] E_ZERO, E_FETCH, E_DECODE, E_WB, E_MEM_ADDR, E_MEM_RD, E_MEM_WB,
                 E_MEM_WR, E_ORI, E_ADDI, E_ANDI, E_BEQ, E_BNE, E_SLL, E_OR_R, E_JUMP;

    initial begin
        E_ZERO     = pk(2'd0, 3'd0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_FETCH    = pk(2'd0, 3'd0, 0, 0, 3'd1, 2'd0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        E_DECODE   = pk(2'd0, 3'd0, 1, 0, 3'd3, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_WB       = pk(2'd0, 3'd0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        E_MEM_ADDR = pk(2'd0, 3'd0, 1, 1, 3'd2, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_MEM_RD   = pk(2'd0, 3'd0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        E_MEM_WB   = pk(2'd0, 3'd0, 0, 0, 3'd0, 2'd0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        E_MEM_WR   = pk(2'd0, 3'd0, 0, 0, 3'd0, 2'd0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        E_ORI      = pk(2'd0, 3'd3, 0, 1, 3'd2, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_ADDI     = pk(2'd0, 3'd0, 1, 1, 3'd2, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_ANDI     = pk(2'd0, 3'd2, 0, 1, 3'd2, 2'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_BEQ      = pk(2'd1, 3'd1, 0, 1, 3'd0, 2'd0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        E_BNE      = pk(2'd1, 3'd1, 0, 1, 3'd0, 2'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        E_SLL      = pk(2'd0, 3'd5, 0, 1, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_OR_R     = pk(2'd0, 3'd3, 0, 1, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_JUMP     = pk(2'd2, 3'd0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    end

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        rst        = 1'b0;
        opcode     = 4'b0000;
        func_field = 4'b0000;

        // Reset, then first FETCH
        step();
        check("reset_all_zero", observed(), E_ZERO);
        rst = 1'b1;
        step();
        check("first_fetch", observed(), E_FETCH);

        // ORI: back in FETCH on the fifth cycle
        opcode = 4'b0011;
        step(); check("ori_decode", observed(), E_DECODE);
        step(); check("ori_exec_i", observed(), E_ORI);
        step(); check("ori_wb_i", observed(), E_WB);
        step(); check("ori_fetch", observed(), E_FETCH);

        // ADDI sign-extends, ANDI zero-extends
        opcode = 4'b0001;
        step(); check("addi_decode", observed(), E_DECODE);
        step(); check("addi_exec_i", observed(), E_ADDI);
        step(); check("addi_wb_i", observed(), E_WB);
        step(); check("addi_fetch", observed(), E_FETCH);
        opcode = 4'b0010;
        step(); step(); check("andi_exec_i", observed(), E_ANDI);
        step(); step(); check("andi_fetch", observed(), E_FETCH);

        // LW: five cycles
        opcode = 4'b0100;
        step(); check("lw_decode", observed(), E_DECODE);
        step(); check("lw_mem_addr", observed(), E_MEM_ADDR);
        step(); check("lw_mem_rd", observed(), E_MEM_RD);
        step(); check("lw_mem_wb", observed(), E_MEM_WB);
        step(); check("lw_fetch", observed(), E_FETCH);

        // SW: four cycles
        opcode = 4'b0101;
        step(); check("sw_decode", observed(), E_DECODE);
        step(); check("sw_mem_addr", observed(), E_MEM_ADDR);
        step(); check("sw_mem_wr", observed(), E_MEM_WR);
        step(); check("sw_fetch", observed(), E_FETCH);

        // BEQ / BNE: three cycles
        opcode = 4'b0110;
        step(); check("beq_decode", observed(), E_DECODE);
        step(); check("beq_branch", observed(), E_BEQ);
        step(); check("beq_fetch", observed(), E_FETCH);
        opcode = 4'b0111;
        step(); step(); check("bne_branch", observed(), E_BNE);
        step(); check("bne_fetch", observed(), E_FETCH);

        // R-type sll, then func_field[3]=1 still executes low bits (or)
        opcode = 4'b0000;
        func_field = 4'b0101;
        step(); check("r_decode", observed(), E_DECODE);
        step(); check("r_exec_sll", observed(), E_SLL);
        step(); check("r_wb_r", observed(), E_WB);
        step(); check("r_fetch", observed(), E_FETCH);
        func_field = 4'b1011;
        step(); step(); check("r_exec_func3_set", observed(), E_OR_R);
        step(); step(); check("r2_fetch", observed(), E_FETCH);

        // NOP opcode: two cycles, no enables in DECODE
        opcode = 4'b1111;
        step(); check("nop_decode", observed(), E_DECODE);
        step(); check("nop_fetch", observed(), E_FETCH);

        // JMP: present only with the jump feature
        opcode = 4'b1000;
        step(); check("jmp_decode", observed(), E_DECODE);
`ifdef CTRL_JUMP_EN
        step(); check("jmp_jump", observed(), E_JUMP);
        step(); check("jmp_fetch", observed(), E_FETCH);
`else
        step(); check("jmp_as_nop_fetch", observed(), E_FETCH);
`endif

        // Reset asserted during MEM_RD aborts the load
        opcode = 4'b0100;
        step(); step(); step();
        check("abort_mem_rd", observed(), E_MEM_RD);
        rst = 1'b0;
        step(); check("abort_reset", observed(), E_ZERO);
        step(); check("abort_reset_held", observed(), E_ZERO);
        rst = 1'b1;
        step(); check("abort_refetch", observed(), E_FETCH);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
